// File: rtl/audio_sink_arb_if.sv
// audio_sink_arb_if: sample requester offers and the codec sink handshake for audio_sink_arb.
interface audio_sink_arb_if #(
    parameter int NSRC = 3,
    parameter int DW = 24
);
    logic [NSRC-1:0]         src_valid;
    logic [NSRC*DW-1:0]      src_data;
    logic [NSRC-1:0]         src_ready;
    logic [DW-1:0]           sink_data;
    logic                    sink_valid;
    logic                    sink_ready;
    logic                    sink_fill;
    logic [$clog2(NSRC)-1:0] grant_id;
    modport master (
        output src_valid, src_data, sink_ready,
        input  src_ready, sink_data, sink_valid, sink_fill, grant_id
    );
    modport slave (
        input  src_valid, src_data, sink_ready,
        output src_ready, sink_data, sink_valid, sink_fill, grant_id
    );
endinterface

// File: rtl/audio_sink_arb.sv
// audio_sink_arb: round-robin sample arbiter into a one-entry codec register with silence fill on starvation.
module audio_sink_arb #(
    parameter int NSRC = 3,
    parameter int DW = 24,
    parameter int IDLE_CYCLES = 1024
) (
    input logic clk,
    input logic rst_n,
    audio_sink_arb_if.slave bus
);
    localparam int IW = $clog2(NSRC);
    localparam int CW = $clog2(IDLE_CYCLES);
    logic [IW-1:0] last, win, idx;
    logic [CW-1:0] idle_cnt;
    logic free, any, grant, fill;
    assign free = !bus.sink_valid || bus.sink_ready;
    assign any = |bus.src_valid;
    // rst_n gates the grant so no source is strobed while the register is held in reset
    assign grant = rst_n && free && any;
    assign fill = free && !any && idle_cnt == CW'(IDLE_CYCLES - 1);
    assign bus.src_ready = grant ? NSRC'(1) << win : '0;
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = NSRC; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % NSRC);
            if (bus.src_valid[idx]) win = idx;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sink_data <= '0;
            bus.sink_valid <= 1'b0;
            bus.sink_fill <= 1'b0;
            bus.grant_id <= '0;
            idle_cnt <= '0;
            last <= IW'(NSRC - 1);
        end else begin
            idle_cnt <= (grant || fill) ? '0 : (free && !any) ? idle_cnt + 1'b1 : idle_cnt;
            if (grant) begin
                bus.sink_data <= bus.src_data[int'(win)*DW +: DW];
                bus.sink_valid <= 1'b1;
                bus.sink_fill <= 1'b0;
                bus.grant_id <= win;
                last <= win;
            end else if (fill) begin
                bus.sink_data <= '0;
                bus.sink_valid <= 1'b1;
                bus.sink_fill <= 1'b1;
                bus.grant_id <= '0;
            end else if (free) begin
                bus.sink_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_audio_sink_arb.sv
// tb_audio_sink_arb: vector table plus hand sequences; delivered samples are checked against a queue of expected samples.
module tb_audio_sink_arb;
    typedef struct {
        logic [2:0] v;
        logic       r;
        logic [2:0] er;
        logic       esv;
    } vec_t;
    typedef struct packed {
        logic [23:0] d;
        logic        f;
        logic [1:0]  g;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [23:0] sd [3];
    exp_t sb[$];
    vec_t tbl[17];
    int checks = 0;
    int errors = 0;
    audio_sink_arb_if #(.NSRC(3), .DW(24)) bus();
    audio_sink_arb #(.NSRC(3), .DW(24), .IDLE_CYCLES(1024)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    assign bus.src_data = {sd[2], sd[1], sd[0]};
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    function automatic logic [1:0] oh2i(input logic [2:0] oh);
        return oh[2] ? 2'd2 : oh[1] ? 2'd1 : 2'd0;
    endfunction
    // Called at posedge+1: drive, check at negedge, then advance to the next posedge+1.
    task automatic cyc(input logic [2:0] v, input logic r, input logic [2:0] er, input logic ef, input logic esv, input string nm);
        exp_t e;
        bus.src_valid = v;
        bus.sink_ready = r;
        @(negedge clk);
        chk({nm, " sink_valid"}, 32'(bus.sink_valid), 32'(esv));
        if (bus.sink_valid && bus.sink_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s delivery: got data %h fill %b with nothing expected", nm, bus.sink_data, bus.sink_fill);
            end else begin
                e = sb.pop_front();
                chk({nm, " sink_data"}, 32'(bus.sink_data), 32'(e.d));
                chk({nm, " sink_fill"}, 32'(bus.sink_fill), 32'(e.f));
                chk({nm, " grant_id"}, 32'(bus.grant_id), 32'(e.g));
            end
        end
        chk({nm, " src_ready"}, 32'(bus.src_ready), 32'(er));
        if (er != 3'b000) sb.push_back('{d: sd[oh2i(er)], f: 1'b0, g: oh2i(er)});
        if (ef) sb.push_back('{d: 24'h0, f: 1'b1, g: 2'd0});
        @(posedge clk);
        #1;
    endtask
    initial begin
        tbl[0]  = '{3'b111, 1'b1, 3'b001, 1'b0};
        tbl[1]  = '{3'b111, 1'b1, 3'b010, 1'b1};
        tbl[2]  = '{3'b111, 1'b1, 3'b100, 1'b1};
        tbl[3]  = '{3'b111, 1'b1, 3'b001, 1'b1};
        tbl[4]  = '{3'b111, 1'b1, 3'b010, 1'b1};
        tbl[5]  = '{3'b111, 1'b1, 3'b100, 1'b1};
        tbl[6]  = '{3'b100, 1'b1, 3'b100, 1'b1};
        tbl[7]  = '{3'b101, 1'b1, 3'b001, 1'b1};
        tbl[8]  = '{3'b101, 1'b1, 3'b100, 1'b1};
        tbl[9]  = '{3'b010, 1'b1, 3'b010, 1'b1};
        tbl[10] = '{3'b000, 1'b1, 3'b000, 1'b1};
        tbl[11] = '{3'b000, 1'b1, 3'b000, 1'b0};
        tbl[12] = '{3'b011, 1'b0, 3'b001, 1'b0};
        tbl[13] = '{3'b011, 1'b0, 3'b000, 1'b1};
        tbl[14] = '{3'b011, 1'b1, 3'b010, 1'b1};
        tbl[15] = '{3'b000, 1'b1, 3'b000, 1'b1};
        tbl[16] = '{3'b000, 1'b1, 3'b000, 1'b0};
        sd[0] = 24'h800001;
        sd[1] = 24'h7FFFFE;
        sd[2] = 24'h5A5A5A;
        bus.src_valid = 3'b000;
        bus.sink_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.src_valid = 3'b111;
        bus.sink_ready = 1'b1;
        @(negedge clk);
        chk("reset sink_valid", 32'(bus.sink_valid), 32'd0);
        chk("reset sink_data", 32'(bus.sink_data), 32'd0);
        chk("reset sink_fill", 32'(bus.sink_fill), 32'd0);
        chk("reset grant_id", 32'(bus.grant_id), 32'd0);
        chk("reset src_ready", 32'(bus.src_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        foreach (tbl[i]) cyc(tbl[i].v, tbl[i].r, tbl[i].er, 1'b0, tbl[i].esv, $sformatf("vec%0d", i));
        sd[1] = 24'h123456;
        cyc(3'b010, 1'b0, 3'b010, 1'b0, 1'b0, "stall grant");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall sink_valid", 32'(bus.sink_valid), 32'd1);
            chk("stall sink_data", 32'(bus.sink_data), 32'h123456);
            chk("stall grant_id", 32'(bus.grant_id), 32'd1);
            chk("stall src_ready", 32'(bus.src_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        cyc(3'b010, 1'b1, 3'b010, 1'b0, 1'b1, "stall release");
        cyc(3'b000, 1'b1, 3'b000, 1'b0, 1'b1, "stall drain");
        cyc(3'b000, 1'b1, 3'b000, 1'b0, 1'b0, "stall empty");
        cyc(3'b001, 1'b0, 3'b001, 1'b0, 1'b0, "rst grant");
        cyc(3'b001, 1'b0, 3'b000, 1'b0, 1'b1, "rst stall");
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset sink_valid", 32'(bus.sink_valid), 32'd0);
        chk("async reset sink_data", 32'(bus.sink_data), 32'd0);
        chk("async reset src_ready", 32'(bus.src_ready), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(3'b111, 1'b1, 3'b001, 1'b0, 1'b0, "post reset grant");
        // Fills at 1023/2047, a grant wins at counter 1023 (i=3071), next fill 1024 cycles later.
        for (int i = 0; i < 4098; i++)
            cyc(i == 3071 ? 3'b001 : 3'b000, 1'b1, i == 3071 ? 3'b001 : 3'b000,
                i == 1023 || i == 2047 || i == 4095,
                i == 0 || i == 1024 || i == 2048 || i == 3072 || i == 4096, "idle");
        chk("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
